// File: rtl/spatial_gate_apply_unit_pkg.sv
// Shared types and helpers for the spatial gate apply path and its requant stage.
package spatial_gate_apply_unit_pkg;

  typedef enum logic [0:0] {
    S_WAIT_GATE = 1'b0,
    S_STREAM    = 1'b1
  } state_e;

  // Largest value representable in a signed w-bit word.
  function automatic int sat_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest value representable in a signed w-bit word.
  function automatic int sat_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

  // Counter width that still works for a single-channel configuration.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/requant_saturate.sv
// Combinational requantiser: arithmetic right shift of a double-width product, then clamp to DATA_W.
module requant_saturate
  import spatial_gate_apply_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC   = 6
) (
  input  logic signed [2*DATA_W-1:0] prod_i,
  output logic signed [DATA_W-1:0]   data_o
);

  localparam int unsigned ProdW = 2 * DATA_W;
  localparam logic signed [ProdW-1:0] MaxV = ProdW'(sat_max(DATA_W));
  localparam logic signed [ProdW-1:0] MinV = ProdW'(sat_min(DATA_W));

  logic signed [ProdW-1:0] shifted;

  // Arithmetic shift rounds toward negative infinity.
  assign shifted = prod_i >>> FRAC;

  always_comb begin
    data_o = shifted[DATA_W-1:0];
    if (shifted > MaxV) begin
      data_o = MaxV[DATA_W-1:0];
    end else if (shifted < MinV) begin
      data_o = MinV[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/spatial_gate_apply_unit.sv
// Broadcasts one per-pixel spatial gate over IN_CH serial channel samples, gating each sample.
module spatial_gate_apply_unit
  import spatial_gate_apply_unit_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned IN_CH     = 8,
  parameter int unsigned GATE_FRAC = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_gate_valid,
  input  logic signed [DATA_W-1:0] i_gate,
  output logic                     o_gate_ready,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_last,
  input  logic                     i_ready
);

  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned CntW  = cnt_width(IN_CH);
  localparam logic [CntW-1:0] LastCh = CntW'(IN_CH - 1);

  state_e                    state_q, state_d;
  logic [CntW-1:0]           ch_cnt_q, ch_cnt_d;
  logic signed [DATA_W-1:0]  gate_q, gate_d;
  logic                      valid_q, valid_d;
  logic signed [DATA_W-1:0]  data_q, data_d;
  logic                      last_q, last_d;

  logic                      gate_acc;
  logic                      feat_acc;
  logic                      last_ch;
  logic signed [ProdW-1:0]   prod;
  logic signed [DATA_W-1:0]  gated;

  assign o_gate_ready = (state_q == S_WAIT_GATE);
  // Stall only when a held output is not being drained this cycle.
  assign o_ready      = (state_q == S_STREAM) && (!valid_q || i_ready);

  assign gate_acc = i_gate_valid && o_gate_ready;
  assign feat_acc = i_valid && o_ready;
  assign last_ch  = (ch_cnt_q == LastCh);

  assign prod = ProdW'(i_data) * ProdW'(gate_q);

  requant_saturate #(
    .DATA_W (DATA_W),
    .FRAC   (GATE_FRAC)
  ) u_requant_saturate (
    .prod_i (prod),
    .data_o (gated)
  );

  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    gate_d   = gate_q;
    unique case (state_q)
      S_WAIT_GATE: begin
        if (gate_acc) begin
          gate_d   = i_gate;
          ch_cnt_d = '0;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (feat_acc) begin
          if (last_ch) begin
            ch_cnt_d = '0;
            state_d  = S_WAIT_GATE;
          end else begin
            ch_cnt_d = ch_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = S_WAIT_GATE;
    endcase
  end

  // Output register: a new sample replaces the held one; a drain without refill empties it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (feat_acc) begin
      valid_d = 1'b1;
      data_d  = gated;
      last_d  = last_ch;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_WAIT_GATE;
      ch_cnt_q <= '0;
      gate_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
      gate_q   <= gate_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_spatial_gate_apply_unit.sv
// Directed bench for spatial_gate_apply_unit at DATA_W=8, IN_CH=8, GATE_FRAC=6.
module tb_spatial_gate_apply_unit;

  typedef logic signed [7:0] vec_t [8];

  logic              clk;
  logic              rst_n;
  logic              i_gate_valid;
  logic signed [7:0] i_gate;
  logic              o_gate_ready;
  logic              i_valid;
  logic signed [7:0] i_data;
  logic              o_ready;
  logic              o_valid;
  logic signed [7:0] o_data;
  logic              o_last;
  logic              i_ready;

  int n_total;
  int n_pass;

  int cyc;
  int nfeat;
  int last_feat_cyc;
  int last_gate_cyc;
  int gate_gap;
  int feat_gap;
  logic [8:0] got [$];

  vec_t ramp_in, ramp_exp;
  vec_t floor_in, floor_exp;
  vec_t clamp_in, clamp_exp;
  vec_t neg_in, neg_exp;

  spatial_gate_apply_unit #(
    .DATA_W    (8),
    .IN_CH     (8),
    .GATE_FRAC (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_gate_valid (i_gate_valid),
    .i_gate       (i_gate),
    .o_gate_ready (o_gate_ready),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_last       (o_last),
    .i_ready      (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: logs delivered outputs and accept timing.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (o_valid && i_ready) got.push_back({o_last, o_data});
      if (i_valid && o_ready) begin
        nfeat = nfeat + 1;
        last_feat_cyc = cyc;
      end
      if (i_gate_valid && o_gate_ready) begin
        gate_gap = cyc - last_gate_cyc;
        feat_gap = cyc - last_feat_cyc;
        last_gate_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic put_gate(input logic signed [7:0] g);
    bit ok;
    ok = 1'b0;
    i_gate_valid = 1'b1;
    i_gate = g;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (o_gate_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    i_gate_valid = 1'b0;
    if (!ok) check("gate_accept_timeout", 0, 1);
  endtask

  task automatic put_feats(input vec_t f, input int n);
    bit ok;
    for (int c = 0; c < n; c++) begin
      ok = 1'b0;
      i_valid = 1'b1;
      i_data = f[c];
      for (int k = 0; k < 200; k++) begin
        @(posedge clk);
        if (o_ready) begin
          ok = 1'b1;
          break;
        end
      end
      @(negedge clk);
      if (!ok) check($sformatf("feat_accept_timeout_ch%0d", c), 0, 1);
    end
    i_valid = 1'b0;
  endtask

  task automatic check_pixel(input string tag, input vec_t exp);
    logic [8:0] e;
    for (int c = 0; c < 8; c++) begin
      if (got.size() == 0) begin
        check($sformatf("%s_missing_ch%0d", tag, c), 0, 1);
      end else begin
        e = got.pop_front();
        check($sformatf("%s_data_ch%0d", tag, c), int'($signed(e[7:0])), int'(exp[c]));
        check($sformatf("%s_last_ch%0d", tag, c), int'(e[8]), (c == 7) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int nfeat0;
    n_total = 0;
    n_pass = 0;
    cyc = 0;
    nfeat = 0;
    last_feat_cyc = 0;
    last_gate_cyc = 0;
    gate_gap = 0;
    feat_gap = 0;
    rst_n = 1'b0;
    i_gate_valid = 1'b0;
    i_gate = '0;
    i_valid = 1'b0;
    i_data = '0;
    i_ready = 1'b1;

    ramp_in   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
    ramp_exp  = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
    floor_in  = '{-8'sd3, 8'sd5, -8'sd1, 8'sd0, 8'sd7, -8'sd8, 8'sd100, -8'sd100};
    floor_exp = '{-8'sd2, 8'sd2, -8'sd1, 8'sd0, 8'sd3, -8'sd4, 8'sd50, -8'sd50};
    clamp_in  = '{8'sd127, -8'sd128, 8'sd1, -8'sd1, 8'sd2, 8'sd64, -8'sd64, 8'sd0};
    clamp_exp = '{8'sd127, -8'sd128, 8'sd1, -8'sd2, 8'sd3, 8'sd127, -8'sd127, 8'sd0};
    neg_in    = '{-8'sd128, 8'sd127, 8'sd1, -8'sd1, 8'sd64, -8'sd64, 8'sd2, 8'sd0};
    neg_exp   = '{8'sd127, -8'sd127, -8'sd1, 8'sd1, -8'sd64, 8'sd64, -8'sd2, 8'sd0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_o_data", int'(o_data), 0);
    check("rst_o_last", int'(o_last), 0);
    check("rst_o_gate_ready", int'(o_gate_ready), 1);
    check("rst_o_ready", int'(o_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unity gate, then half gate back to back (floor rounding, 9 cycles per pixel)
    put_gate(8'sd64);
    put_feats(ramp_in, 8);
    put_gate(8'sd32);
    check("pixel_period", gate_gap, 9);
    check("gate_after_last_feat", feat_gap, 1);
    put_feats(floor_in, 8);
    repeat (3) @(negedge clk);
    check_pixel("unity", ramp_exp);
    check_pixel("floor", floor_exp);

    // Saturation at both rails
    put_gate(8'sd127);
    put_feats(clamp_in, 8);
    repeat (3) @(negedge clk);
    check_pixel("clamp", clamp_exp);

    // Downstream stall for 3 cycles mid-pixel
    put_gate(8'sd64);
    fork
      put_feats(ramp_in, 8);
      begin
        repeat (4) @(negedge clk);
        i_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_o_ready", int'(o_ready), 0);
          check("stall_o_valid", int'(o_valid), 1);
          check("stall_o_data", int'(o_data), 4);
        end
        i_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    check_pixel("stall", ramp_exp);

    // Features offered before the gate are held off
    nfeat0 = nfeat;
    fork
      put_feats(neg_in, 8);
      begin
        repeat (3) @(negedge clk);
        check("early_o_ready", int'(o_ready), 0);
        check("early_no_accept", nfeat - nfeat0, 0);
        put_gate(-8'sd64);
      end
    join
    repeat (3) @(negedge clk);
    check_pixel("neg_gate", neg_exp);

    // Next gate held during a stream is taken right after the last feature
    put_gate(8'sd64);
    fork
      put_feats(ramp_in, 8);
      put_gate(8'sd32);
    join
    check("held_gate_timing", feat_gap, 1);
    put_feats(floor_in, 8);
    repeat (3) @(negedge clk);
    check_pixel("held_a", ramp_exp);
    check_pixel("held_b", floor_exp);

    // Reset after 3 channels, then a fresh pixel
    put_gate(8'sd64);
    put_feats(ramp_in, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_o_valid", int'(o_valid), 0);
    check("midrst_o_gate_ready", int'(o_gate_ready), 1);
    check("midrst_o_data", int'(o_data), 0);
    check("midrst_o_last", int'(o_last), 0);
    check("midrst_o_ready", int'(o_ready), 0);
    rst_n = 1'b1;
    got.delete();
    @(negedge clk);
    put_gate(8'sd127);
    put_feats(clamp_in, 8);
    repeat (3) @(negedge clk);
    check_pixel("post_rst", clamp_exp);
    check("no_extra_outputs", got.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
